// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: funct3 encodings, store FSM states, store request payload.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned LANE_W = 2;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } store_state_t;

  typedef struct packed {
    logic [F3_W-1:0]   func3;
    logic [LANE_W-1:0] lane;
    logic [XLEN-1:0]   data;
  } store_req_t;

  // A store is legal when funct3 is a store encoding and the address is naturally aligned.
  function automatic logic store_legal(input logic [F3_W-1:0] func3,
                                       input logic [LANE_W-1:0] lane);
    case (func3)
      F3_SB:   return 1'b1;
      F3_SH:   return ~lane[0];
      F3_SW:   return (lane == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte-lane merge of store data into an existing memory word.
module store_merge
  import riscv_pkg::*;
(
  input  logic [F3_W-1:0]   func3,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   old_word,
  output logic [XLEN-1:0]   merged_c
);

  always_comb begin
    merged_c = old_word;
    case (func3)
      F3_SB:   merged_c[8*lane +: 8]      = store_data[7:0];
      F3_SH:   merged_c[16*lane[1] +: 16] = store_data[15:0];
      F3_SW:   merged_c                   = store_data;
      default: merged_c                   = old_word;
    endcase
  end

endmodule

// File: rtl/store_data_unit.sv
// MEM-stage store unit: aligns rs2 into byte lanes, read-modify-write for sub-word stores.
module store_data_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              mem_write,
  input  logic [F3_W-1:0]   func3,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   store_data,
  output logic              busywait,
  output logic              misaligned,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [XLEN-1:0]   dmem_writedata,
  input  logic [XLEN-1:0]   dmem_readdata,
  input  logic              dmem_busywait
);

  store_state_t    state_q, state_d;
  store_req_t      req_q;
  logic            legal_c;
  logic            accept_c;
  logic [XLEN-1:0] merged_c;

  assign legal_c  = store_legal(func3, address[1:0]);
  assign accept_c = (state_q == ST_IDLE) && mem_write && legal_c;

  // Stall and error flags are combinational so they act in the request cycle.
  assign busywait   = accept_c || (state_q == ST_RD) || (state_q == ST_WR);
  assign misaligned = (state_q == ST_IDLE) && mem_write && !legal_c;

  store_merge u_merge (
    .func3      (req_q.func3),
    .lane       (req_q.lane),
    .store_data (req_q.data),
    .old_word   (dmem_readdata),
    .merged_c   (merged_c)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)      state_d = (func3 == F3_SW) ? ST_WR : ST_RD;
      ST_RD:   if (!dmem_busywait) state_d = ST_WR;
      ST_WR:   if (!dmem_busywait) state_d = ST_DONE;
      ST_DONE:                    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // State, operand latches and registered dmem interface.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      dmem_read      <= 1'b0;
      dmem_write     <= 1'b0;
      dmem_address   <= '0;
      dmem_writedata <= '0;
    end else begin
      state_q    <= state_d;
      dmem_read  <= (state_d == ST_RD);
      dmem_write <= (state_d == ST_WR);
      if (accept_c) begin
        req_q.func3    <= func3;
        req_q.lane     <= address[1:0];
        req_q.data     <= store_data;
        dmem_address   <= {address[ADDR_W-1:2], 2'b00};
        dmem_writedata <= store_data;
      end else if ((state_q == ST_RD) && !dmem_busywait) begin
        dmem_writedata <= merged_c;
      end
    end
  end

endmodule

// File: tb/tb_store_data_unit.sv
// Self-checking bench for store_data_unit with a wait-state memory model and write/read scoreboard.
module tb_store_data_unit;
  import riscv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busywait;
  logic        misaligned;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_writedata;
  logic [31:0] dmem_readdata;
  logic        dmem_busywait;

  store_data_unit #(.ADDR_W(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .mem_write      (mem_write),
    .func3          (func3),
    .address        (address),
    .store_data     (store_data),
    .busywait       (busywait),
    .misaligned     (misaligned),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_address   (dmem_address),
    .dmem_writedata (dmem_writedata),
    .dmem_readdata  (dmem_readdata),
    .dmem_busywait  (dmem_busywait)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Memory model: wait_n busy cycles per access, commits on the first non-busy edge.
  int          wait_n = 0;
  int          wcnt   = 0;
  int          ovl    = 0;
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [63:0] obs_wr_q[$], exp_wr_q[$];
  logic [63:0] obs_rd_q[$], exp_rd_q[$];

  assign dmem_readdata = mem[dmem_address[7:2]];
  assign dmem_busywait = (dmem_read || dmem_write) && (wcnt < wait_n);

  always @(posedge CLK) begin
    if (dmem_read && dmem_write) ovl++;
    if ((dmem_read || dmem_write) && dmem_busywait) wcnt <= wcnt + 1;
    else                                            wcnt <= 0;
    if (dmem_read && !dmem_busywait) obs_rd_q.push_back({dmem_address, dmem_readdata});
    if (dmem_write && !dmem_busywait) begin
      mem[dmem_address[7:2]] <= dmem_writedata;
      obs_wr_q.push_back({dmem_address, dmem_writedata});
    end
    if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] d, input logic [31:0] old);
    logic [31:0] mask;
    logic [31:0] sh;
    if (f3 == 3'b010) return d;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh   = (f3 == 3'b000) ? {27'd0, lane, 3'd0} : {27'd0, lane[1], 4'd0};
    mask = mask << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge CLK);
    pre_en  = 1'b1;
    pre_idx = addr[7:2];
    pre_val = val;
    ref_mem[addr[7:2]] = val;
    @(negedge CLK);
    pre_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    check({tag, ":wr_count"}, 64'(obs_wr_q.size()), 64'(exp_wr_q.size()));
    check({tag, ":rd_count"}, 64'(obs_rd_q.size()), 64'(exp_rd_q.size()));
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0)
      check({tag, ":write"}, obs_wr_q.pop_front(), exp_wr_q.pop_front());
    while (exp_rd_q.size() > 0 && obs_rd_q.size() > 0)
      check({tag, ":read"}, obs_rd_q.pop_front(), exp_rd_q.pop_front());
    obs_wr_q.delete(); exp_wr_q.delete();
    obs_rd_q.delete(); exp_rd_q.delete();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int exp_busy);
    logic       legal;
    logic [5:0] idx;
    int         cyc;
    legal = (f3 == 3'b000) || (f3 == 3'b001 && !addr[0]) || (f3 == 3'b010 && addr[1:0] == 2'b00);
    idx   = addr[7:2];
    @(negedge CLK);
    mem_write  = 1'b1;
    func3      = f3;
    address    = addr;
    store_data = data;
    if (legal) begin
      if (f3 != 3'b010) exp_rd_q.push_back({addr & 32'hFFFF_FFFC, ref_mem[idx]});
      ref_mem[idx] = ref_merge(f3, addr[1:0], data, ref_mem[idx]);
      exp_wr_q.push_back({addr & 32'hFFFF_FFFC, ref_mem[idx]});
    end
    #1;
    check({tag, ":misaligned"}, 64'(misaligned), 64'(!legal));
    cyc = 0;
    while (busywait && cyc < 100) begin
      cyc++;
      @(negedge CLK);
      #1;
    end
    check({tag, ":busy_cycles"}, 64'(cyc), 64'(exp_busy));
    if (!legal) begin
      @(negedge CLK);
      #1;
    end
    mem_write = 1'b0;
    drain(tag);
  endtask

  initial begin
    RESET      = 1'b1;
    mem_write  = 1'b0;
    func3      = 3'b000;
    address    = '0;
    store_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst:busywait",   64'(busywait),   64'd0);
    check("rst:misaligned", 64'(misaligned), 64'd0);
    check("rst:dmem_read",  64'(dmem_read),  64'd0);
    check("rst:dmem_write", 64'(dmem_write), 64'd0);
    check("rst:dmem_addr",  64'(dmem_address),   64'd0);
    check("rst:dmem_wdata", 64'(dmem_writedata), 64'd0);
    RESET = 1'b0;

    preload(32'h00, 32'h0000_0000);
    preload(32'h10, 32'h0000_0000);
    preload(32'h20, 32'h1122_3344);
    preload(32'h30, 32'h1122_3344);
    preload(32'h40, 32'h0000_0000);
    preload(32'h50, 32'h5555_5555);

    wait_n = 0;
    do_store("sw", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 2);
    check("sw:word", 64'(mem[4]), 64'h0000_0000_DEAD_BEEF);
    do_store("sb", 3'b000, 32'h0000_0021, 32'hAABB_CCDD, 3);
    check("sb:word", 64'(mem[8]), 64'h0000_0000_1122_DD44);

    wait_n = 2;
    do_store("sh_wait", 3'b001, 32'h0000_0032, 32'h0000_BEEF, 7);
    check("sh_wait:word", 64'(mem[12]), 64'h0000_0000_BEEF_3344);
    wait_n = 0;

    do_store("mis_sh", 3'b001, 32'h0000_0031, 32'h1234_5678, 0);
    do_store("mis_sw", 3'b010, 32'h0000_0012, 32'h1234_5678, 0);
    do_store("mis_f3", 3'b011, 32'h0000_0010, 32'h1234_5678, 0);
    check("mis:word", 64'(mem[4]), 64'h0000_0000_DEAD_BEEF);

    // Reset while the read is stalled by memory.
    wait_n = 10;
    @(negedge CLK);
    mem_write  = 1'b1;
    func3      = 3'b000;
    address    = 32'h0000_0051;
    store_data = 32'h0000_00AB;
    @(negedge CLK);
    check("rst_rd:in_rd", 64'(dmem_read), 64'd1);
    RESET     = 1'b1;
    mem_write = 1'b0;
    @(negedge CLK);
    check("rst_rd:busywait",   64'(busywait),       64'd0);
    check("rst_rd:dmem_read",  64'(dmem_read),      64'd0);
    check("rst_rd:dmem_write", 64'(dmem_write),     64'd0);
    check("rst_rd:dmem_addr",  64'(dmem_address),   64'd0);
    check("rst_rd:dmem_wdata", 64'(dmem_writedata), 64'd0);
    RESET  = 1'b0;
    wait_n = 0;
    repeat (3) @(negedge CLK);
    drain("rst_rd");
    check("rst_rd:word", 64'(mem[20]), 64'h0000_0000_5555_5555);

    do_store("b2b_1", 3'b000, 32'h0000_0041, 32'h0000_00DD, 3);
    do_store("b2b_2", 3'b000, 32'h0000_0042, 32'h0000_00DD, 3);
    check("b2b:word", 64'(mem[16]), 64'h0000_0000_00DD_DD00);

    check("rd_wr_overlap", 64'(ovl), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
